dmem_access_unit: RTL and testbench

- Memory-stage load/store unit between the pipeline's M stage and the data bus.
- Takes the M-stage address (aluoutM), store data (writedataM) and access controls, and runs a request/grant/response handshake with a wait-state data bus.
- Produces byte-aligned, sign- or zero-extended readdataM.
- Holds stallM high until the access completes; flags misaligned accesses and bus timeouts.

---
 rtl/dmem_access_unit.sv | 153 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: aligns, strobes and replicates M-stage accesses,
// runs a req/gnt/rvalid handshake with a wait-state data bus, and extends load data.
//
// state  | meaning
// IDLE   | no access in flight; stallM follows memenM & aligned
// REQ    | dbus_req asserted, waiting for dbus_gnt
// WAIT_R | request accepted, waiting for dbus_rvalid or timeout
// DONE   | result presented; held while stallextM=1 so the access is not reissued
module dmem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memenM,
   input  logic        memwriteM,
   input  logic [1:0]  memsizeM,
   input  logic        memsignM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   input  logic        stallextM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        adelM,
   output logic        adesM,
   output logic        buserrM,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [3:0]  dbus_wstrb,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_gnt,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_rdata;
   logic        r_buserr;

   logic        w_aligned;
   logic        w_start;
   logic        w_in_req;
   logic        w_in_done;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   always_comb begin
      w_aligned = 1'b1;
      w_wstrb   = 4'b1111;
      w_wdata   = writedataM;
      case (memsizeM)
         2'b00: begin
            w_aligned = 1'b1;
            w_wstrb   = 4'b0001 << aluoutM[1:0];
            w_wdata   = {4{writedataM[7:0]}};
         end
         2'b01: begin
            w_aligned = ~aluoutM[0];
            w_wstrb   = aluoutM[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{writedataM[15:0]}};
         end
         default: begin
            w_aligned = (aluoutM[1:0] == 2'b00);
            w_wstrb   = 4'b1111;
            w_wdata   = writedataM;
         end
      endcase
      if (!memwriteM) w_wstrb = 4'b0000;
   end

   assign w_start = memenM & w_aligned;

   always_comb begin
      w_byte = r_rdata[{aluoutM[1:0], 3'b000} +: 8];
      w_half = r_rdata[{aluoutM[1], 4'b0000} +: 16];
      case (memsizeM)
         2'b00:   w_load = {{24{memsignM & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{memsignM & w_half[15]}}, w_half};
         default: w_load = r_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= 8'd0;
         r_rdata  <= 32'd0;
         r_buserr <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_buserr <= 1'b0;
               if (w_start) r_state <= REQ;
            end
            REQ: begin
               if (dbus_gnt) begin
                  r_cnt <= 8'd0;
                  if (dbus_rvalid) begin
                     r_rdata  <= dbus_rdata;
                     r_buserr <= 1'b0;
                     r_state  <= DONE;
                  end else begin
                     r_state <= WAIT_R;
                  end
               end
            end
            WAIT_R: begin
               // a response arriving on the last allowed cycle still wins over the timeout
               if (dbus_rvalid) begin
                  r_rdata  <= dbus_rdata;
                  r_buserr <= 1'b0;
                  r_state  <= DONE;
               end else if (r_cnt == TO_LAST) begin
                  r_buserr <= 1'b1;
                  r_state  <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               if (!stallextM) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_in_req  = (r_state == REQ);
   assign w_in_done = (r_state == DONE);

   // rst gates the input-driven outputs so everything reads 0 while reset is held
   assign stallM = rst & ((r_state == IDLE & w_start) | w_in_req | (r_state == WAIT_R));
   assign adelM  = rst & memenM & ~memwriteM & ~w_aligned;
   assign adesM  = rst & memenM &  memwriteM & ~w_aligned;

   assign dbus_req   = w_in_req;
   assign dbus_we    = w_in_req & memwriteM;
   assign dbus_wstrb = w_in_req ? w_wstrb : 4'b0000;
   assign dbus_addr  = w_in_req ? {aluoutM[31:2], 2'b00} : 32'd0;
   assign dbus_wdata = w_in_req ? w_wdata : 32'd0;

   assign readdataM = (w_in_done & ~memwriteM) ? w_load : 32'd0;
   assign buserrM   = w_in_done & r_buserr;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: vector table for aligned/misaligned accesses
// plus hand sequences for latency, zero-wait bus, timeout hold and mid-access reset.
module tb_dmem_access_unit;

   logic        clk, rst;
   logic        memenM, memwriteM, memsignM, stallextM;
   logic [1:0]  memsizeM;
   logic [31:0] aluoutM, writedataM;
   logic [31:0] readdataM;
   logic        stallM, adelM, adesM, buserrM;
   logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
   logic [3:0]  dbus_wstrb;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   dmem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .memenM(memenM), .memwriteM(memwriteM), .memsizeM(memsizeM), .memsignM(memsignM),
      .aluoutM(aluoutM), .writedataM(writedataM), .stallextM(stallextM),
      .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM), .buserrM(buserrM),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  size;
      logic        we;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        exp_adel;
      logic        exp_ades;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdm;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [1:0] sz, input logic we, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd);
      memenM     = 1'b1;
      memsizeM   = sz;
      memwriteM  = we;
      memsignM   = sg;
      aluoutM    = ad;
      writedataM = wd;
   endtask

   // Called at a negedge with inputs applied; returns sampled at the DONE cycle.
   // rv_lat: 0 = rvalid with gnt, N = rvalid N cycles after gnt, -1 = never.
   task automatic run_access(input int rv_lat, input logic [31:0] rd,
                             output int n_stall, output int n_req,
                             output logic [3:0] s_wstrb, output logic [31:0] s_addr,
                             output logic [31:0] s_wdata, output logic s_we,
                             output logic [31:0] s_rdm, output logic s_berr);
      int wcnt;
      bit in_wait;
      bit done;
      n_stall = 0; n_req = 0; wcnt = 0; in_wait = 0; done = 0;
      s_wstrb = '0; s_addr = '0; s_wdata = '0; s_we = 1'b0; s_rdm = '0; s_berr = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (!stallM && n_stall > 0) begin
            done   = 1;
            s_rdm  = readdataM;
            s_berr = buserrM;
         end else begin
            if (stallM) n_stall++;
            if (dbus_req) begin
               n_req++;
               s_wstrb = dbus_wstrb;
               s_addr  = dbus_addr;
               s_wdata = dbus_wdata;
               s_we    = dbus_we;
            end
            if (in_wait) wcnt++;
            dbus_gnt    = dbus_req;
            dbus_rvalid = (dbus_req && rv_lat == 0) || (in_wait && wcnt == rv_lat);
            dbus_rdata  = dbus_rvalid ? rd : 32'h5A5A5A5A;
            if (dbus_req) in_wait = 1;
            @(negedge clk);
         end
      end
      dbus_gnt    = 1'b0;
      dbus_rvalid = 1'b0;
      chk("access_completes", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int          ns, nr;
      logic [3:0]  sw;
      logic [31:0] sa, swd, srd;
      logic        swe, sbe;
      int          reqs;

      vecs[0]  = '{2'b10, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF};
      vecs[1]  = '{2'b00, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80};
      vecs[2]  = '{2'b00, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'h00000080};
      vecs[3]  = '{2'b00, 1'b0, 1'b1, 32'h0000_0101, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0000007F};
      vecs[4]  = '{2'b01, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'hFFFF80FF};
      vecs[5]  = '{2'b01, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 4'h0, 32'h0, 32'h00007F01};
      vecs[6]  = '{2'b01, 1'b1, 1'b0, 32'h0000_0022, 32'h0000ABCD, 32'h11111111, 1'b0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
      vecs[7]  = '{2'b00, 1'b1, 1'b0, 32'h0000_0045, 32'h123456A5, 32'h22222222, 1'b0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
      vecs[8]  = '{2'b10, 1'b1, 1'b0, 32'h0000_0080, 32'hCAFEF00D, 32'h33333333, 1'b0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
      vecs[9]  = '{2'b11, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h01234567, 1'b0, 1'b0, 4'h0, 32'h0, 32'h01234567};
      vecs[10] = '{2'b10, 1'b0, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
      vecs[11] = '{2'b01, 1'b1, 1'b0, 32'h0000_0033, 32'h1234, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
      vecs[12] = '{2'b01, 1'b0, 1'b1, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
      vecs[13] = '{2'b11, 1'b1, 1'b0, 32'h0000_0102, 32'h9, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0};

      rst = 1'b0; stallextM = 1'b0;
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
      set_in(2'b10, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ctrl_outs", {26'd0, stallM, dbus_req, dbus_we, buserrM, adelM, adesM}, 32'd0);
      chk("reset_bus_outs", dbus_addr | dbus_wdata | readdataM | {28'd0, dbus_wstrb}, 32'd0);
      memenM = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         set_in(vecs[i].size, vecs[i].we, vecs[i].sgn, vecs[i].addr, vecs[i].wd);
         if (vecs[i].exp_adel || vecs[i].exp_ades) begin
            reqs = 0;
            for (int c = 0; c < 3; c++) begin
               #1;
               chk($sformatf("v%0d_adel", i), {31'd0, adelM}, {31'd0, vecs[i].exp_adel});
               chk($sformatf("v%0d_ades", i), {31'd0, adesM}, {31'd0, vecs[i].exp_ades});
               chk($sformatf("v%0d_stall", i), {31'd0, stallM}, 32'd0);
               if (dbus_req) reqs++;
               @(negedge clk);
            end
            chk($sformatf("v%0d_no_req", i), reqs, 32'd0);
            memenM = 1'b0;
         end else begin
            #1;
            chk($sformatf("v%0d_flags", i), {30'd0, adelM, adesM}, 32'd0);
            run_access(1, vecs[i].rd, ns, nr, sw, sa, swd, swe, srd, sbe);
            chk($sformatf("v%0d_stall_cycles", i), ns, 32'd3);
            chk($sformatf("v%0d_req_cycles", i), nr, 32'd1);
            chk($sformatf("v%0d_wstrb", i), {28'd0, sw}, {28'd0, vecs[i].exp_wstrb});
            chk($sformatf("v%0d_addr", i), sa, vecs[i].addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_we", i), {31'd0, swe}, {31'd0, vecs[i].we});
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), swd, vecs[i].exp_wdata);
            chk($sformatf("v%0d_readdata", i), srd, vecs[i].exp_rdm);
            chk($sformatf("v%0d_buserr", i), {31'd0, sbe}, 32'd0);
            memenM = 1'b0;
            @(negedge clk);
         end
      end

      // rvalid two cycles after gnt: four stall cycles
      set_in(2'b10, 1'b0, 1'b0, 32'h100, 32'h0);
      run_access(2, 32'hDEADBEEF, ns, nr, sw, sa, swd, swe, srd, sbe);
      chk("lat2_stall_cycles", ns, 32'd4);
      chk("lat2_req_cycles", nr, 32'd1);
      chk("lat2_readdata", srd, 32'hDEADBEEF);
      memenM = 1'b0;
      @(negedge clk);

      // gnt and rvalid together in REQ
      set_in(2'b01, 1'b0, 1'b0, 32'h102, 32'h0);
      run_access(0, 32'h12345678, ns, nr, sw, sa, swd, swe, srd, sbe);
      chk("zw_stall_cycles", ns, 32'd2);
      chk("zw_readdata", srd, 32'h00001234);
      memenM = 1'b0;
      @(negedge clk);

      // timeout, then DONE held by stallextM
      set_in(2'b10, 1'b0, 1'b0, 32'h100, 32'h0);
      run_access(-1, 32'h0, ns, nr, sw, sa, swd, swe, srd, sbe);
      chk("to_stall_cycles", ns, 32'd6);
      chk("to_req_cycles", nr, 32'd1);
      chk("to_buserr", {31'd0, sbe}, 32'd1);
      stallextM = 1'b1;
      reqs = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("hold%0d_buserr", c), {31'd0, buserrM}, 32'd1);
         chk($sformatf("hold%0d_stall", c), {31'd0, stallM}, 32'd0);
         if (dbus_req) reqs++;
      end
      chk("hold_no_req", reqs, 32'd0);
      stallextM = 1'b0;
      memenM = 1'b0;
      @(negedge clk);
      #1;
      chk("after_hold_idle", {30'd0, buserrM, stallM}, 32'd0);
      @(negedge clk);

      // reset asserted during WAIT_R
      set_in(2'b10, 1'b0, 1'b0, 32'h300, 32'h0);
      #1;
      chk("mr_idle_stall", {31'd0, stallM}, 32'd1);
      @(negedge clk);
      #1;
      chk("mr_req", {31'd0, dbus_req}, 32'd1);
      dbus_gnt = 1'b1;
      @(negedge clk);
      dbus_gnt = 1'b0;
      #1;
      chk("mr_wait_state", {30'd0, stallM, dbus_req}, 32'd2);
      rst = 1'b0;
      #1;
      chk("mr_ctrl_outs", {26'd0, stallM, dbus_req, dbus_we, buserrM, adelM, adesM}, 32'd0);
      chk("mr_bus_outs", dbus_addr | dbus_wdata | readdataM | {28'd0, dbus_wstrb}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      set_in(2'b10, 1'b0, 1'b0, 32'h304, 32'h0);
      run_access(1, 32'h0BADF00D, ns, nr, sw, sa, swd, swe, srd, sbe);
      chk("mr_restart_stall", ns, 32'd3);
      chk("mr_restart_addr", sa, 32'h304);
      chk("mr_restart_readdata", srd, 32'h0BADF00D);
      memenM = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
